// File: rtl/aes_cbc_dec_ctrl_if.sv
// Signal bundle between aes_cbc_dec_ctrl and its environment: ciphertext
// input stream, plaintext output stream, decryption core hookup and status.
interface aes_cbc_dec_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             cbc_en;
  logic [127:0]     iv_in;
  logic             iv_load;
  logic             s_valid;
  logic             s_ready;
  logic [127:0]     s_data;
  logic             m_valid;
  logic             m_ready;
  logic [127:0]     m_data;
  logic             core_ready;
  logic             core_start;
  logic [127:0]     core_cipher_text;
  logic [127:0]     core_plain_text;
  logic             core_done;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] blk_count;

  modport master (
    output cbc_en, iv_in, iv_load, s_valid, s_data, m_ready,
           core_ready, core_plain_text, core_done,
    input  s_ready, m_valid, m_data, core_start, core_cipher_text,
           busy, err, blk_count
  );

  modport slave (
    input  cbc_en, iv_in, iv_load, s_valid, s_data, m_ready,
           core_ready, core_plain_text, core_done,
    output s_ready, m_valid, m_data, core_start, core_cipher_text,
           busy, err, blk_count
  );
endinterface

// File: rtl/aes_cbc_dec_ctrl.sv
// Streaming CBC/ECB front-end for the AES decryption core: launches one block
// at a time, applies chaining XOR on completion, and buffers one output block.
module aes_cbc_dec_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 32
) (
  input logic              clk,
  input logic              reset,
  aes_cbc_dec_ctrl_if.slave bus
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_OUT
  } state_t;

  state_t           state;
  logic [127:0]     chain_reg;
  logic [127:0]     ct_reg;
  logic             mode_reg;
  logic [TW-1:0]    tcnt;
  logic             done_q;
  logic             core_start_q;
  logic             m_valid_q;
  logic [127:0]     m_data_q;
  logic             err_q;
  logic [CNT_W-1:0] blk_count_q;
  logic             s_ready_w;
  logic             done_rise;

  assign s_ready_w = (state == S_IDLE) && bus.core_ready && !bus.iv_load;
  assign done_rise = bus.core_done && !done_q;

  assign bus.s_ready          = s_ready_w;
  assign bus.busy             = (state != S_IDLE);
  assign bus.core_start       = core_start_q;
  assign bus.core_cipher_text = ct_reg;
  assign bus.m_valid          = m_valid_q;
  assign bus.m_data           = m_data_q;
  assign bus.err              = err_q;
  assign bus.blk_count        = blk_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      chain_reg    <= '0;
      ct_reg       <= '0;
      mode_reg     <= 1'b0;
      tcnt         <= '0;
      done_q       <= 1'b0;
      core_start_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      err_q        <= 1'b0;
      blk_count_q  <= '0;
    end else begin
      // done_q tracks every cycle so a level already high on WAIT entry is no edge
      done_q       <= bus.core_done;
      core_start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.iv_load) begin
            chain_reg <= bus.iv_in;
            err_q     <= 1'b0;
          end else if (bus.s_valid && s_ready_w) begin
            ct_reg       <= bus.s_data;
            mode_reg     <= bus.cbc_en;
            core_start_q <= 1'b1;
            state        <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (done_rise) begin
            m_data_q  <= bus.core_plain_text ^ (mode_reg ? chain_reg : '0);
            if (mode_reg) chain_reg <= ct_reg;
            m_valid_q <= 1'b1;
            state     <= S_OUT;
          end else if (tcnt == T_LAST) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_OUT: begin
          if (bus.m_ready) begin
            m_valid_q   <= 1'b0;
            blk_count_q <= blk_count_q + 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cbc_dec_ctrl.sv
// Directed bench for aes_cbc_dec_ctrl with a behavioural decryption core that
// returns precomputed raw AES block decryptions after a fixed latency.
module tb_aes_cbc_dec_ctrl;

  localparam int CW = 32;

  localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] P2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C3 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P3 = 128'h3243f6a8885a308d313198a2e0370734;

  logic clk = 1'b0;
  logic reset;
  int   vec  = 0;
  int   miss = 0;

  aes_cbc_dec_ctrl_if #(.CNT_W(CW)) bus ();

  aes_cbc_dec_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Raw block decryption D(C): CBC plaintext is D(C) ^ previous ciphertext.
  function automatic logic [127:0] core_dec(input logic [127:0] ct);
    case (ct)
      C1:      return P1 ^ IV;
      C2:      return P2 ^ C1;
      C3:      return P3;
      default: return '0;
    endcase
  endfunction

  logic stub_dead = 1'b0;
  int   start_cnt = 0;
  int   lat       = 0;

  always @(posedge clk) begin
    if (reset) begin
      bus.core_done       <= 1'b0;
      bus.core_plain_text <= '0;
      lat                 <= 0;
    end else if (bus.core_start) begin
      start_cnt     <= start_cnt + 1;
      bus.core_done <= 1'b0;
      lat           <= 4;
    end else if (lat > 0) begin
      lat <= lat - 1;
      if (lat == 1 && !stub_dead) begin
        bus.core_done       <= 1'b1;
        bus.core_plain_text <= core_dec(bus.core_cipher_text);
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_block(input string tag, input logic [127:0] ct, input logic cbc,
                           input logic [127:0] exp_pt, input int hold);
    int n;
    int s0;
    logic [127:0] held;
    s0 = start_cnt;
    @(negedge clk);
    bus.s_data  = ct;
    bus.cbc_en  = cbc;
    bus.s_valid = 1'b1;
    n = 0;
    while (!bus.s_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_accept_timeout"}, 128'(n < 50), 128'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk({tag, "_core_start"}, 128'(bus.core_start), 128'd1);
    chk({tag, "_core_ct"}, bus.core_cipher_text, ct);
    n = 0;
    while (!bus.m_valid && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_m_valid"}, 128'(bus.m_valid), 128'd1);
    chk({tag, "_m_data"}, bus.m_data, exp_pt);
    held = bus.m_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_bp_m_valid"}, 128'(bus.m_valid), 128'd1);
      chk({tag, "_bp_m_data"}, bus.m_data, held);
      chk({tag, "_bp_s_ready"}, 128'(bus.s_ready), 128'd0);
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    chk({tag, "_post_m_valid"}, 128'(bus.m_valid), 128'd0);
    chk({tag, "_post_s_ready"}, 128'(bus.s_ready), 128'd1);
    chk({tag, "_start_pulses"}, 128'(start_cnt - s0), 128'd1);
  endtask

  initial begin
    int s0;
    reset           = 1'b1;
    bus.cbc_en      = 1'b1;
    bus.iv_in       = '0;
    bus.iv_load     = 1'b0;
    bus.s_valid     = 1'b0;
    bus.s_data      = '0;
    bus.m_ready     = 1'b0;
    bus.core_ready  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 128'(bus.s_ready), 128'd0);
    chk("rst_m_valid", 128'(bus.m_valid), 128'd0);
    chk("rst_m_data", bus.m_data, 128'd0);
    chk("rst_core_start", 128'(bus.core_start), 128'd0);
    chk("rst_core_ct", bus.core_cipher_text, 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_err", 128'(bus.err), 128'd0);
    chk("rst_blk_count", 128'(bus.blk_count), 128'd0);
    reset = 1'b0;

    // IV load wins over a simultaneous s_valid
    @(negedge clk);
    bus.core_ready = 1'b1;
    bus.iv_in      = IV;
    bus.iv_load    = 1'b1;
    bus.s_valid    = 1'b1;
    bus.s_data     = C1;
    s0 = start_cnt;
    chk("ivp_s_ready", 128'(bus.s_ready), 128'd0);
    @(negedge clk);
    bus.iv_load = 1'b0;
    bus.s_valid = 1'b0;
    chk("ivp_busy", 128'(bus.busy), 128'd0);
    chk("ivp_no_start", 128'(start_cnt - s0), 128'd0);

    // CBC two-block vector
    run_block("cbc1", C1, 1'b1, P1, 0);
    run_block("cbc2", C2, 1'b1, P2, 0);
    chk("cbc_blk_count", 128'(bus.blk_count), 128'd2);

    // ECB leaves the chain at C2 for the next CBC block
    run_block("ecb", C3, 1'b0, P3, 0);
    run_block("cbc_resume", C1, 1'b1, P1 ^ IV ^ C2, 0);

    // Backpressure: chain now C1
    run_block("bp", C1, 1'b1, P1 ^ IV ^ C1, 20);
    chk("bp_blk_count", 128'(bus.blk_count), 128'd5);

    // Key not ready
    @(negedge clk);
    bus.core_ready = 1'b0;
    bus.s_valid    = 1'b1;
    bus.s_data     = C2;
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("nokey_s_ready", 128'(bus.s_ready), 128'd0);
    end
    chk("nokey_busy", 128'(bus.busy), 128'd0);
    chk("nokey_no_start", 128'(start_cnt - s0), 128'd0);
    bus.s_valid    = 1'b0;
    bus.core_ready = 1'b1;

    // Timeout: WAIT lasts TIMEOUT_CYCLES cycles, err visible the cycle after
    stub_dead = 1'b1;
    @(negedge clk);
    bus.s_data  = C2;
    bus.s_valid = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk("to_core_start", 128'(bus.core_start), 128'd1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("to_err_early", 128'(bus.err), 128'd0);
      chk("to_busy", 128'(bus.busy), 128'd1);
      chk("to_m_valid", 128'(bus.m_valid), 128'd0);
    end
    @(negedge clk);
    chk("to_err_set", 128'(bus.err), 128'd1);
    chk("to_idle", 128'(bus.busy), 128'd0);
    chk("to_no_output", 128'(bus.m_valid), 128'd0);
    repeat (3) @(negedge clk);
    chk("to_err_sticky", 128'(bus.err), 128'd1);
    bus.iv_in   = IV;
    bus.iv_load = 1'b1;
    @(negedge clk);
    bus.iv_load = 1'b0;
    chk("to_err_cleared", 128'(bus.err), 128'd0);
    stub_dead = 1'b0;

    // Asynchronous reset in the middle of WAIT
    @(negedge clk);
    bus.s_data  = C1;
    bus.cbc_en  = 1'b1;
    bus.s_valid = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    chk("mid_core_start", 128'(bus.core_start), 128'd1);
    @(negedge clk);
    chk("mid_busy_before", 128'(bus.busy), 128'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 128'(bus.busy), 128'd0);
    chk("mid_rst_m_valid", 128'(bus.m_valid), 128'd0);
    chk("mid_rst_core_start", 128'(bus.core_start), 128'd0);
    chk("mid_rst_blk_count", 128'(bus.blk_count), 128'd0);
    chk("mid_rst_core_ct", bus.core_cipher_text, 128'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_no_output", 128'(bus.m_valid), 128'd0);
    bus.iv_in   = IV;
    bus.iv_load = 1'b1;
    @(negedge clk);
    bus.iv_load = 1'b0;
    run_block("after_rst", C1, 1'b1, P1, 0);
    chk("after_rst_blk_count", 128'(bus.blk_count), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/aes_cbc_dec_ctrl.md
# aes_cbc_dec_ctrl

Streaming front-end for the `decryption` core. It accepts 128-bit ciphertext blocks over a valid/ready interface and launches the core one block at a time using `cipher_text` and a single-cycle `start`. It captures the core's `plain_text` when `done_dec` rises and applies CBC chaining: XOR with the IV or with the previous ciphertext. The resulting plaintext is presented on a valid/ready output with one block of buffering. It sits between the host DMA/bus adapter and the `decryption` core, and shares key readiness (`ready_dec`) from `key_expansion`.

## Interface

**Parameters**
- `TIMEOUT_CYCLES`, default 64: maximum cycles in WAIT for `core_done` before the block aborts with an error.
- `CNT_W`, default 32: width of the block counter.

**Ports** (one clock; reset is asynchronous and active-high)
- `clk` in 1: clock, all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cbc_en` in 1: 1 selects CBC decrypt, 0 selects ECB pass-through (no XOR). Sampled at input accept.
- `iv_in` in 128: initialisation vector.
- `iv_load` in 1: loads `iv_in` into the chain register. Honoured only in IDLE.
- `s_valid` in 1, `s_ready` out 1, `s_data` in 128: ciphertext input stream.
- `m_valid` out 1, `m_ready` in 1, `m_data` out 128: plaintext output stream.
- `core_ready` in 1: `ready_dec` from `key_expansion`.
- `core_start` out 1: to `decryption.start`.
- `core_cipher_text` out 128: to `decryption.cipher_text`.
- `core_plain_text` in 128: from `decryption.plain_text`.
- `core_done` in 1: from `decryption.done_dec`.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: sticky timeout flag.
- `blk_count` out CNT_W: number of blocks delivered on `m`.

## Operation

- FSM states are IDLE, LAUNCH, WAIT and OUT.
- **IDLE**
  - `s_ready = core_ready & ~iv_load`.
  - When `iv_load` is high: `chain_reg <= iv_in` and `err <= 0`. `iv_load` takes precedence over `s_valid` in the same cycle.
  - On `s_valid & s_ready`: `ct_reg <= s_data`, `mode_reg <= cbc_en`, then go to LAUNCH.
- **LAUNCH**
  - `core_start = 1` for exactly this one cycle.
  - `core_cipher_text = ct_reg`, held stable from LAUNCH through the end of WAIT.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - Detect the rising edge of `core_done` against a registered copy of `core_done`. A `core_done` that is already high on WAIT entry is not accepted.
  - On the rising edge:
    - `m_data <= core_plain_text ^ (mode_reg ? chain_reg : 0)`.
    - If `mode_reg` is set, `chain_reg <= ct_reg`.
    - Go to OUT.
  - If the timeout counter reaches `TIMEOUT_CYCLES - 1` with no edge: `err <= 1`, chain register unchanged, no output produced, return to IDLE.
- **OUT**
  - `m_valid = 1`. `m_data` is held stable while `m_ready` is low.
  - On `m_valid & m_ready`: `blk_count <= blk_count + 1` (wraps modulo 2^CNT_W), then go to IDLE.
- `iv_load` outside IDLE is ignored; `chain_reg` is unchanged.
- ECB blocks (`mode_reg = 0`) leave `chain_reg` untouched, so CBC can resume afterwards.
- Reset at any time, including mid-operation, aborts the in-flight block. The state returns to IDLE, `chain_reg` and `ct_reg` clear, and no output is emitted for the aborted block.

## Timing

- Reset values:
  - `s_ready = 0` (then follows `core_ready` in IDLE).
  - `m_valid = 0`, `m_data = 0`, `core_start = 0`, `core_cipher_text = 0`.
  - `busy = 0`, `err = 0`, `blk_count = 0`, `chain_reg = 0`.
- Accept in cycle T leads to `core_start` high in T+1.
- A `core_done` rising edge sampled in cycle D leads to `m_valid` high in D+1.
- An output handshake in cycle H leads to `s_ready` high again in H+1 (if `core_ready` is high).
- Throughput is one block per (core latency + 3) cycles, with no overlap.
- All outputs are registered except `s_ready` and `busy`, which are decoded from state.

## Test plan

- **CBC, two blocks.** Key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f.
  - CT 7649abac8119b246cee98e9b12e9197d → `m_data` 6bc1bee22e409f96e93d7e117393172a.
  - CT 5086cb9b507219ee95db113a917678b2 → `m_data` ae2d8a571e03ac9c9eb76fac45af8e51.
  - `blk_count` = 2.
- **ECB.** `cbc_en = 0`, CT 3925841d02dc09fbdc118597196a0b32 → `m_data` 3243f6a8885a308d313198a2e0370734. The following CBC block still chains from the earlier CBC ciphertext.
- **Backpressure.** Hold `m_ready = 0` for 20 cycles in OUT → `m_valid` and `m_data` stay stable, `s_ready = 0`, and exactly one `core_start` pulse is seen per block.
- **Key not ready and IV precedence.**
  - `core_ready = 0` with `s_valid = 1` → `s_ready = 0` and no `core_start`.
  - `iv_load` together with `s_valid` in IDLE → IV loaded, block not accepted that cycle.
- **Timeout.** Use a stub core that never asserts done, with `TIMEOUT_CYCLES = 8` → `err = 1` exactly 8 cycles after LAUNCH, back to IDLE, `m_valid` never asserted. A following `iv_load` clears `err`.
- **Reset mid-WAIT.** Assert `reset` asynchronously between clock edges → `busy`, `m_valid`, `core_start` and `blk_count` go to 0 immediately. After release, the CBC vector decrypts correctly once the IV is reloaded.
